rep_hist_wr: RTL and testbench

- Write-side manager for the repetition-detector history RAM.
- Keeps a full per-ply shadow history of {castle_mask, board}, tracks the start of the reversible window (ply of the last irreversible move), and drives the detector's RAM write port and window depth.
- On push it writes the new position into the window.
- On a pop that undoes an irreversible move, it re-copies the restored window from its shadow into detector RAM addresses 0..depth-1.
- Sits between the search/move sequencer and the repetition detector.

---
 rtl/rep_hist_wr.sv | 190 +++++++++++++++++++
 tb/tb_rep_hist_wr.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rep_hist_wr.sv
// rep_hist_wr: write-side manager for the repetition-detector history RAM.
// Keeps a per-ply shadow of every pushed {castle_mask, board} plus the window
// base in force before each push. Pushes land directly in the detector RAM.
// A pop that crosses an irreversible move re-copies the restored window from
// the shadow into detector addresses 0..depth-1.

`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module rep_hist_wr #(
    parameter int REPDET_WIDTH = 8,
    parameter int PLY_WIDTH    = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [`BOARD_WIDTH-1:0] cmd_board,
    input  logic [3:0]              cmd_castle_mask,
    input  logic                    cmd_irreversible,
    input  logic                    hold,
    output logic [`BOARD_WIDTH-1:0] ram_board_out,
    output logic [3:0]              ram_castle_mask_out,
    output logic [REPDET_WIDTH-1:0] ram_wr_addr_out,
    output logic                    ram_wr_en,
    output logic [REPDET_WIDTH-1:0] ram_depth_out,
    output logic [PLY_WIDTH:0]      ply_out,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int EW        = `BOARD_WIDTH + 4;
    localparam int PW1       = PLY_WIDTH + 1;
    localparam int PLY_DEPTH = 1 << PLY_WIDTH;
    localparam logic [PW1-1:0] PLY_COUNT = PW1'(PLY_DEPTH);
    localparam logic [31:0]    WIN_MAX   = 32'((1 << REPDET_WIDTH) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP_RD,
        S_POP_CHK,
        S_COPY_RD,
        S_COPY_WR
    } state_t;

    state_t                  r_state;
    logic [PW1-1:0]          r_ply;
    logic [PW1-1:0]          r_cur_base;
    logic [PW1-1:0]          r_idx;
    logic [REPDET_WIDTH-1:0] r_depth;
    logic                    r_wr_en;
    logic [REPDET_WIDTH-1:0] r_wr_addr;
    logic [EW-1:0]           r_wr_data;
    logic                    r_ovf;
    logic                    r_unf;

    // Shadow RAMs and their registered read ports
    logic [EW-1:0]  r_hist     [PLY_DEPTH];
    logic [PW1-1:0] r_base_stk [PLY_DEPTH];
    logic [EW-1:0]  r_hist_rd;
    logic [PW1-1:0] r_base_rd;

    logic                 w_fire;
    logic                 w_push_rej;
    logic                 w_push_ok;
    logic [PW1-1:0]       w_win_len;
    logic [PW1-1:0]       w_new_base;
    logic [PW1-1:0]       w_idx_next;
    logic [EW-1:0]        w_entry;
    logic [PLY_WIDTH-1:0] w_ply_idx;
    logic [PLY_WIDTH-1:0] w_hist_rd_addr;

    assign cmd_ready      = (r_state == S_IDLE) && !hold && !reset;
    assign w_fire         = cmd_valid && cmd_ready;
    assign w_win_len      = r_ply - r_cur_base;
    assign w_push_rej     = (r_ply == PLY_COUNT) ||
                            (!cmd_irreversible && (32'(w_win_len) == WIN_MAX));
    assign w_push_ok      = w_fire && (cmd_op == 2'd1) && !w_push_rej;
    assign w_new_base     = cmd_irreversible ? r_ply : r_cur_base;
    assign w_idx_next     = r_idx + PW1'(1);
    assign w_entry        = {cmd_castle_mask, cmd_board};
    assign w_ply_idx      = r_ply[PLY_WIDTH-1:0];
    // After POP_CHK r_cur_base already holds the restored base, so the copy
    // source is simply cur_base + i.
    assign w_hist_rd_addr = PLY_WIDTH'(r_cur_base + r_idx);

    // A write registered just before hold rose stays pending and is released
    // when hold drops, so no strobe is lost and none overlaps hold.
    assign ram_wr_en           = r_wr_en && !hold;
    assign ram_wr_addr_out     = r_wr_addr;
    assign ram_board_out       = r_wr_data[`BOARD_WIDTH-1:0];
    assign ram_castle_mask_out = r_wr_data[EW-1 -: 4];
    assign ram_depth_out       = r_depth;
    assign ply_out             = r_ply;
    assign overflow            = r_ovf;
    assign underflow           = r_unf;

    // Shadow RAM writes on accepted push; reads run every cycle from addresses
    // derived from held state, so a stalled read simply repeats itself.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_hist[w_ply_idx]     <= w_entry;
            r_base_stk[w_ply_idx] <= r_cur_base;
        end
        r_base_rd <= r_base_stk[w_ply_idx];
        r_hist_rd <= r_hist[w_hist_rd_addr];
    end

    // Command handling, pop base check and window re-copy state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ply      <= '0;
            r_cur_base <= '0;
            r_idx      <= '0;
            r_depth    <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else if (!hold) begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        case (cmd_op)
                            2'd1: begin
                                if (w_push_rej) begin
                                    r_ovf <= 1'b1;
                                end else begin
                                    r_wr_en    <= 1'b1;
                                    r_wr_addr  <= REPDET_WIDTH'(r_ply - w_new_base);
                                    r_wr_data  <= w_entry;
                                    r_cur_base <= w_new_base;
                                    r_ply      <= r_ply + PW1'(1);
                                    r_depth    <= REPDET_WIDTH'(r_ply + PW1'(1) - w_new_base);
                                end
                            end
                            2'd2: begin
                                if (r_ply == '0) begin
                                    r_unf <= 1'b1;
                                end else begin
                                    r_ply   <= r_ply - PW1'(1);
                                    r_state <= S_POP_RD;
                                end
                            end
                            2'd3: begin
                                r_ply      <= '0;
                                r_cur_base <= '0;
                                r_depth    <= '0;
                                r_ovf      <= 1'b0;
                                r_unf      <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_POP_RD: r_state <= S_POP_CHK;
                S_POP_CHK: begin
                    if (r_base_rd == r_cur_base) begin
                        r_depth <= REPDET_WIDTH'(r_ply - r_base_rd);
                        r_state <= S_IDLE;
                    end else begin
                        r_cur_base <= r_base_rd;
                        r_idx      <= '0;
                        r_state    <= S_COPY_RD;
                    end
                end
                S_COPY_RD: r_state <= S_COPY_WR;
                S_COPY_WR: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= REPDET_WIDTH'(r_idx);
                    r_wr_data <= r_hist_rd;
                    r_idx     <= w_idx_next;
                    if (w_idx_next == w_win_len) begin
                        r_depth <= REPDET_WIDTH'(w_win_len);
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_COPY_RD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rep_hist_wr.sv
// tb_rep_hist_wr: table vectors, directed multi-cycle sequences and a random
// run checked against a stack/window reference model.

`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module tb_rep_hist_wr;

    localparam int BW        = `BOARD_WIDTH;
    localparam int EW        = BW + 4;
    localparam int RW        = 8;
    localparam int PW        = 7;
    localparam int PLY_COUNT = 1 << PW;
    localparam int RAM_COUNT = 1 << RW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // main DUT
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [BW-1:0] cmd_board = '0;
    logic [3:0]    cmd_castle_mask = '0;
    logic          cmd_irreversible = 1'b0;
    logic          hold_dir = 1'b0;
    logic          hold_rnd = 1'b0;
    wire           hold = hold_dir | hold_rnd;
    logic [BW-1:0] ram_board_out;
    logic [3:0]    ram_castle_mask_out;
    logic [RW-1:0] ram_wr_addr_out;
    logic          ram_wr_en;
    logic [RW-1:0] ram_depth_out;
    logic [PW:0]   ply_out;
    logic          overflow;
    logic          underflow;

    rep_hist_wr #(.REPDET_WIDTH(RW), .PLY_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_board(cmd_board), .cmd_castle_mask(cmd_castle_mask),
        .cmd_irreversible(cmd_irreversible), .hold(hold),
        .ram_board_out(ram_board_out), .ram_castle_mask_out(ram_castle_mask_out),
        .ram_wr_addr_out(ram_wr_addr_out), .ram_wr_en(ram_wr_en),
        .ram_depth_out(ram_depth_out), .ply_out(ply_out),
        .overflow(overflow), .underflow(underflow)
    );

    // small-window DUT
    logic          b_valid = 1'b0;
    logic          b_ready;
    logic [1:0]    b_op = '0;
    logic [BW-1:0] b_board = '0;
    logic [3:0]    b_castle = '0;
    logic          b_irr = 1'b0;
    logic          b_hold = 1'b0;
    logic [BW-1:0] b_board_o;
    logic [3:0]    b_castle_o;
    logic [1:0]    b_addr;
    logic          b_wr_en;
    logic [1:0]    b_depth;
    logic [3:0]    b_ply;
    logic          b_ovf;
    logic          b_unf;

    rep_hist_wr #(.REPDET_WIDTH(2), .PLY_WIDTH(3)) dut2 (
        .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_op(b_op), .cmd_board(b_board), .cmd_castle_mask(b_castle),
        .cmd_irreversible(b_irr), .hold(b_hold),
        .ram_board_out(b_board_o), .ram_castle_mask_out(b_castle_o),
        .ram_wr_addr_out(b_addr), .ram_wr_en(b_wr_en),
        .ram_depth_out(b_depth), .ply_out(b_ply),
        .overflow(b_ovf), .underflow(b_unf)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // write monitor: detector RAM image plus strobe log
    logic [EW-1:0] tb_ram [RAM_COUNT];
    logic [RW-1:0] log_addr [$];
    logic [EW-1:0] log_data [$];
    logic [RW-1:0] log_depth[$];
    int            log_cyc  [$];
    int            hold_wr_cnt = 0;
    int            b_wr_cnt = 0;
    logic [1:0]    b_last_addr = '0;

    always @(negedge clk) begin
        if (!reset && ram_wr_en === 1'b1) begin
            tb_ram[ram_wr_addr_out] = {ram_castle_mask_out, ram_board_out};
            log_addr.push_back(ram_wr_addr_out);
            log_data.push_back({ram_castle_mask_out, ram_board_out});
            log_depth.push_back(ram_depth_out);
            log_cyc.push_back(cyc);
            if (hold) hold_wr_cnt++;
        end
        if (!reset && b_wr_en === 1'b1) begin
            b_wr_cnt++;
            b_last_addr = b_addr;
        end
    end

    function automatic void clear_log();
        log_addr.delete();
        log_data.delete();
        log_depth.delete();
        log_cyc.delete();
    endfunction

    // random hold noise for the random phase
    bit hold_noise = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        hold_rnd = hold_noise ? ($urandom_range(0, 4) == 0) : 1'b0;
    end

    // called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [1:0] op, input logic [EW-1:0] ent, input logic irr);
        int t = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_board = ent[BW-1:0];
        cmd_castle_mask = ent[EW-1 -: 4];
        cmd_irreversible = irr;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (cmd_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (cmd_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_idle: cmd_ready=%b required 1", cmd_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_b(input logic [1:0] op, input logic [EW-1:0] ent, input logic irr);
        int t = 0;
        b_valid = 1'b1;
        b_op = op;
        b_board = ent[BW-1:0];
        b_castle = ent[EW-1 -: 4];
        b_irr = irr;
        @(negedge clk);
        while (b_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (b_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_b_timeout: ready=%b required 1", b_ready);
        end
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // reference model: the game stack; window = entries from the last
    // irreversible push to the top
    logic [EW-1:0] m_stk[$];
    bit            m_irr[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    function automatic int m_base();
        int b = 0;
        for (int i = 0; i < m_stk.size(); i++) if (m_irr[i]) b = i;
        return b;
    endfunction

    function automatic void model_apply(input logic [1:0] op, input logic [EW-1:0] ent, input bit irr);
        int sz = m_stk.size();
        case (op)
            2'd1: begin
                if (sz == PLY_COUNT || (!irr && (sz - m_base()) == RAM_COUNT - 1)) m_ovf = 1'b1;
                else begin
                    m_stk.push_back(ent);
                    m_irr.push_back(irr);
                end
            end
            2'd2: begin
                if (sz == 0) m_unf = 1'b1;
                else begin
                    void'(m_stk.pop_back());
                    void'(m_irr.pop_back());
                end
            end
            2'd3: begin
                m_stk.delete();
                m_irr.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            default: ;
        endcase
    endfunction

    task automatic check_model(input string tag);
        int b = m_base();
        int d = m_stk.size() - b;
        int bad = 0;
        chk({tag, " depth"}, ram_depth_out, d[RW-1:0]);
        chk({tag, " ply"}, ply_out, m_stk.size());
        chk({tag, " overflow"}, overflow, m_ovf);
        chk({tag, " underflow"}, underflow, m_unf);
        for (int i = 0; i < d; i++) if (tb_ram[i] !== m_stk[b + i]) bad++;
        chk({tag, " window"}, bad, 0);
    endtask

    task automatic do_model(input logic [1:0] op, input logic [EW-1:0] ent, input bit irr, input string tag);
        send(op, ent, irr);
        wait_idle();
        model_apply(op, ent, irr);
        check_model(tag);
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [EW-1:0] ent;
        logic          irr;
        int            nwr;
        int            addr;
        logic [EW-1:0] data;
        int            depth;
        int            ply;
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t          tbl[18];
    logic [EW-1:0] ea, eb, ec, ed, ee;
    logic [EW-1:0] abc[3];

    initial begin
        int lowc;
        int t;
        logic [EW-1:0] rent;
        logic [1:0] rop;
        bit rirr;
        int r;

        ea = {4'h1, BW'(64'hA1A1_0000_0000_00A1)};
        eb = {4'h2, BW'(64'hB2B2_0000_0000_00B2)};
        ec = {4'h4, BW'(64'hC3C3_0000_0000_00C3)};
        ed = {4'h8, BW'(64'hD4D4_0000_0000_00D4)};
        ee = {4'hF, BW'(64'hE5E5_0000_0000_00E5)};
        abc[0] = ea; abc[1] = eb; abc[2] = ec;

        //              op    ent irr nwr addr data depth ply ovf unf
        tbl[0]  = '{2'd0, '0, 1'b0, 0, 0, '0, 0, 0, 1'b0, 1'b0};
        tbl[1]  = '{2'd1, ea, 1'b0, 1, 0, ea, 1, 1, 1'b0, 1'b0};
        tbl[2]  = '{2'd1, eb, 1'b0, 1, 1, eb, 2, 2, 1'b0, 1'b0};
        tbl[3]  = '{2'd1, ec, 1'b0, 1, 2, ec, 3, 3, 1'b0, 1'b0};
        tbl[4]  = '{2'd1, ed, 1'b1, 1, 0, ed, 1, 4, 1'b0, 1'b0};
        tbl[5]  = '{2'd1, ee, 1'b0, 1, 1, ee, 2, 5, 1'b0, 1'b0};
        tbl[6]  = '{2'd2, '0, 1'b0, 0, 0, '0, 1, 4, 1'b0, 1'b0};
        tbl[7]  = '{2'd2, '0, 1'b0, 3, 2, ec, 3, 3, 1'b0, 1'b0};
        tbl[8]  = '{2'd2, '0, 1'b0, 0, 0, '0, 2, 2, 1'b0, 1'b0};
        tbl[9]  = '{2'd2, '0, 1'b0, 0, 0, '0, 1, 1, 1'b0, 1'b0};
        tbl[10] = '{2'd2, '0, 1'b0, 0, 0, '0, 0, 0, 1'b0, 1'b0};
        tbl[11] = '{2'd2, '0, 1'b0, 0, 0, '0, 0, 0, 1'b0, 1'b1};
        tbl[12] = '{2'd0, '0, 1'b0, 0, 0, '0, 0, 0, 1'b0, 1'b1};
        tbl[13] = '{2'd3, '0, 1'b0, 0, 0, '0, 0, 0, 1'b0, 1'b0};
        tbl[14] = '{2'd1, ed, 1'b1, 1, 0, ed, 1, 1, 1'b0, 1'b0};
        tbl[15] = '{2'd1, ee, 1'b1, 1, 0, ee, 1, 2, 1'b0, 1'b0};
        tbl[16] = '{2'd2, '0, 1'b0, 1, 0, ed, 1, 1, 1'b0, 1'b0};
        tbl[17] = '{2'd3, '0, 1'b0, 0, 0, '0, 0, 0, 1'b0, 1'b0};

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ready", cmd_ready, 1'b0);
        chk("reset ready_b", b_ready, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post-reset ready", cmd_ready, 1'b1);
        chk("post-reset wr_en", ram_wr_en, 1'b0);
        chk("post-reset depth", ram_depth_out, 0);
        chk("post-reset ply", ply_out, 0);
        chk("post-reset overflow", overflow, 1'b0);
        chk("post-reset underflow", underflow, 1'b0);
        chk("post-reset ply_b", b_ply, 0);
        @(posedge clk);
        #1;

        // small window: 3 reversible fill it, 4th rejected, irreversible restarts
        for (int i = 0; i < 3; i++) send_b(2'd1, abc[i], 1'b0);
        chk("win2 depth", b_depth, 3);
        chk("win2 writes", b_wr_cnt, 3);
        send_b(2'd1, ed, 1'b0);
        chk("win2 reject overflow", b_ovf, 1'b1);
        chk("win2 reject writes", b_wr_cnt, 3);
        chk("win2 reject depth", b_depth, 3);
        chk("win2 reject ply", b_ply, 3);
        send_b(2'd1, ee, 1'b1);
        chk("win2 irr writes", b_wr_cnt, 4);
        chk("win2 irr addr", b_last_addr, 0);
        chk("win2 irr depth", b_depth, 1);

        // table vectors
        for (int i = 0; i < 18; i++) begin
            clear_log();
            send(tbl[i].op, tbl[i].ent, tbl[i].irr);
            wait_idle();
            $display("[TB] vec %0d op=%0d irr=%0d writes=%0d depth=%0d ply=%0d",
                     i, tbl[i].op, tbl[i].irr, log_addr.size(), ram_depth_out, ply_out);
            chk($sformatf("vec%0d nwr", i), log_addr.size(), tbl[i].nwr);
            if (tbl[i].nwr > 0 && log_addr.size() > 0) begin
                chk($sformatf("vec%0d addr", i), log_addr[log_addr.size()-1], tbl[i].addr);
                chk($sformatf("vec%0d data", i), log_data[log_data.size()-1], tbl[i].data);
            end
            chk($sformatf("vec%0d depth", i), ram_depth_out, tbl[i].depth);
            chk($sformatf("vec%0d ply", i), ply_out, tbl[i].ply);
            chk($sformatf("vec%0d ovf", i), overflow, tbl[i].ovf);
            chk($sformatf("vec%0d unf", i), underflow, tbl[i].unf);
        end

        // back-to-back pushes, one per cycle
        clear_log();
        cmd_valid = 1'b1;
        cmd_op = 2'd1;
        cmd_irreversible = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_board = abc[i][BW-1:0];
            cmd_castle_mask = abc[i][EW-1 -: 4];
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        wait_idle();
        chk("b2b writes", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk("b2b spacing01", log_cyc[1] - log_cyc[0], 1);
            chk("b2b spacing12", log_cyc[2] - log_cyc[1], 1);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("b2b addr%0d", i), log_addr[i], i);
                chk($sformatf("b2b data%0d", i), log_data[i], abc[i]);
            end
        end
        chk("b2b depth", ram_depth_out, 3);
        chk("b2b ply", ply_out, 3);
        $display("[TB] b2b push writes=%0d depth=%0d", log_addr.size(), ram_depth_out);

        // copy timing after undoing an irreversible move
        send(2'd1, ed, 1'b1); wait_idle();
        send(2'd1, ee, 1'b0); wait_idle();
        send(2'd2, '0, 1'b0); wait_idle();
        clear_log();
        send(2'd2, '0, 1'b0);
        lowc = 0;
        t = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && t < 100) begin
            lowc++;
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        chk("copy ready-low cycles", lowc, 8);
        chk("copy writes", log_addr.size(), 3);
        if (log_addr.size() == 3) begin
            chk("copy spacing01", log_cyc[1] - log_cyc[0], 2);
            chk("copy spacing12", log_cyc[2] - log_cyc[1], 2);
            chk("copy depth at first strobe", log_depth[0], 1);
            chk("copy depth at last strobe", log_depth[2], 3);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("copy addr%0d", i), log_addr[i], i);
                chk($sformatf("copy data%0d", i), log_data[i], abc[i]);
            end
        end
        chk("copy ply", ply_out, 3);
        $display("[TB] copy writes=%0d ready_low=%0d depth=%0d", log_addr.size(), lowc, ram_depth_out);

        // same copy with hold for 5 cycles after the first strobe
        send(2'd1, ed, 1'b1); wait_idle();
        send(2'd1, ee, 1'b0); wait_idle();
        send(2'd2, '0, 1'b0); wait_idle();
        clear_log();
        send(2'd2, '0, 1'b0);
        t = 0;
        while (log_addr.size() == 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("hold first strobe seen", log_addr.size(), 1);
        @(posedge clk);
        #1;
        hold_dir = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("hold no strobe while held", log_addr.size(), 1);
        hold_dir = 1'b0;
        wait_idle();
        chk("hold writes", log_addr.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("hold ram%0d", i), tb_ram[i], abc[i]);
        chk("hold depth", ram_depth_out, 3);
        chk("hold ply", ply_out, 3);
        $display("[TB] hold copy writes=%0d depth=%0d", log_addr.size(), ram_depth_out);

        // reset in the middle of a copy
        send(2'd1, ed, 1'b1); wait_idle();
        send(2'd1, ee, 1'b0); wait_idle();
        send(2'd2, '0, 1'b0); wait_idle();
        send(2'd2, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midcopy reset depth", ram_depth_out, 0);
        chk("midcopy reset ply", ply_out, 0);
        chk("midcopy reset ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        $display("[TB] mid-copy reset depth=%0d ply=%0d", ram_depth_out, ply_out);

        // fill the shadow stack to capacity, then one more push
        do_model(2'd3, '0, 1'b0, "fill clear");
        for (int i = 0; i < PLY_COUNT; i++) begin
            rent = EW'({$urandom(), $urandom(), $urandom()});
            send(2'd1, rent, 1'b0);
            wait_idle();
            model_apply(2'd1, rent, 1'b0);
        end
        check_model("fill full");
        clear_log();
        do_model(2'd1, ea, 1'b1, "fill overflow");
        chk("fill overflow no write", log_addr.size(), 0);
        do_model(2'd2, '0, 1'b0, "fill pop");
        $display("[TB] fill ply=%0d overflow=%0b", ply_out, overflow);

        // random commands with random hold against the model
        do_model(2'd3, '0, 1'b0, "rand clear");
        hold_noise = 1'b1;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            rop = (r < 60) ? 2'd1 : (r < 92) ? 2'd2 : (r < 95) ? 2'd3 : 2'd0;
            rirr = ($urandom_range(0, 4) == 0);
            rent = EW'({$urandom(), $urandom(), $urandom()});
            do_model(rop, rent, rirr, $sformatf("rand%0d", n));
            $display("[TB] rand %0d op=%0d irr=%0d ply=%0d depth=%0d", n, rop, rirr, ply_out, ram_depth_out);
        end
        hold_noise = 1'b0;
        repeat (2) @(posedge clk);
        chk("strobes during hold", hold_wr_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
